// File: rtl/queue_dispatcher.sv
// queue_dispatcher: consumer side of the fixed-priority queue scheduler.
// Samples the scheduler decision, pops one word from the selected queue into an
// output register, forwards it over valid/ready, then waits a settle interval so
// the registered scheduler observes the updated empty flags before the next pick.
// Optional per-queue dispatch counters: define QUEUE_DISPATCHER_STATS_EN.
module queue_dispatcher #(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned SETTLE_CYCLES    = 2,
    parameter int unsigned COUNT_WIDTH      = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        sched_valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]         sched_selection,
    input  logic [NUMBER_OF_QUEUES-1:0]                 empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]      queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]                 pop,
    output logic                                        out_valid,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]         out_queue_id,
    input  logic                                        out_ready,
    output logic [NUMBER_OF_QUEUES*COUNT_WIDTH-1:0]     dispatch_count
);

    localparam int unsigned SEL_WIDTH    = $clog2(NUMBER_OF_QUEUES);
    localparam int unsigned SETTLE_WIDTH = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_WIDTH-1:0] SETTLE_LOAD = SETTLE_WIDTH'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic [SETTLE_WIDTH-1:0]       settle_cnt;
    logic [SETTLE_WIDTH-1:0]       settle_next;
    logic                          dispatch;
    logic                          handshake;
    logic                          sel_hit;
    logic [DATA_WIDTH-1:0]         sel_data;
    logic [NUMBER_OF_QUEUES-1:0]   sel_onehot;

    // Decode the selection; ids outside the queue range never match, so they never dispatch.
    always_comb begin
        sel_hit    = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (sched_selection == SEL_WIDTH'(i)) begin
                sel_hit       = ~empty[i];
                sel_data      = queue_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state  = state;
        settle_next = settle_cnt;
        dispatch    = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (sched_valid && sel_hit) begin
                    dispatch   = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    handshake   = 1'b1;
                    settle_next = SETTLE_LOAD;
                    next_state  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    settle_next = settle_cnt - SETTLE_WIDTH'(1);
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State and settle counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= next_state;
            settle_cnt <= settle_next;
        end
    end

    // Registered pop strobe: high for exactly the cycle after the dispatch decision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop <= '0;
        end else begin
            pop <= dispatch ? sel_onehot : '0;
        end
    end

    // Output packet register; payload held stable until the handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_queue_id <= '0;
        end else begin
            if (dispatch) begin
                out_valid    <= 1'b1;
                out_data     <= sel_data;
                out_queue_id <= sched_selection;
            end else if (handshake) begin
                out_valid    <= 1'b0;
            end
        end
    end

`ifdef QUEUE_DISPATCHER_STATS_EN
    logic [COUNT_WIDTH-1:0] counts [NUMBER_OF_QUEUES];

    // Saturating per-queue dispatch counters, bumped by each pop strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                counts[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                if (pop[i] && (counts[i] != '1)) begin
                    counts[i] <= counts[i] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        dispatch_count = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            dispatch_count[i*COUNT_WIDTH +: COUNT_WIDTH] = counts[i];
        end
    end
`else
    assign dispatch_count = '0;
`endif

endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench for queue_dispatcher: stimulus pushes expected pops/packets,
// a negedge monitor pops and compares whenever the DUT pops or transfers.
module tb_queue_dispatcher;

    localparam int unsigned NQ = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned SC = 2;
    localparam int unsigned CW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              sched_valid;
    logic [1:0]        sched_selection;
    logic [NQ-1:0]     empty;
    logic [DW-1:0]     qd [NQ];
    logic [NQ*DW-1:0]  queue_data;
    logic [NQ-1:0]     pop;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_queue_id;
    logic              out_ready;
    logic [NQ*CW-1:0]  dispatch_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pop = -1;
    logic [NQ-1:0] exp_pop_q [$];
    logic [65:0]   exp_pkt_q [$];

    assign queue_data = {qd[3], qd[2], qd[1], qd[0]};

    always #5 clock = ~clock;

    queue_dispatcher #(
        .NUMBER_OF_QUEUES(NQ),
        .DATA_WIDTH(DW),
        .SETTLE_CYCLES(SC),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sched_valid(sched_valid),
        .sched_selection(sched_selection),
        .empty(empty),
        .queue_data(queue_data),
        .pop(pop),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_queue_id(out_queue_id),
        .out_ready(out_ready),
        .dispatch_count(dispatch_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Monitor: compare every pop and every transfer against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            last_pop = -1;
        end else begin
            if (pop != '0) begin
                if (exp_pop_q.size() == 0) begin
                    check("unexpected_pop", 128'(pop), 128'(0));
                end else begin
                    check("pop_vector", 128'(pop), 128'(exp_pop_q.pop_front()));
                end
                if (last_pop >= 0) begin
                    check("pop_gap_ok", 128'((cyc - last_pop) >= int'(2 + SC)), 128'(1));
                end
                last_pop = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_pkt_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_transfer: got %0h expected none", {out_queue_id, out_data});
                end else begin
                    check("packet", 128'({out_queue_id, out_data}), 128'(exp_pkt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        sched_valid = 1'b0;
        sched_selection = 2'd0;
        empty = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < NQ; i++) qd[i] = '0;

        // Reset values
        #12;
        check("rst_pop", 128'(pop), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_qid", 128'(out_queue_id), 128'(0));
        check("rst_count", 128'(dispatch_count), 128'(0));
        @(negedge clock);
        reset = 1'b1;

        // All queues empty, no decision: quiet for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_pop", 128'(pop), 128'(0));
            check("idle_valid", 128'(out_valid), 128'(0));
        end

        // Dispatch from queue 2; held decision gives a second pop after the settle gap
        @(posedge clock); #1;
        qd[2] = 64'hA5; empty = 4'b1011; sched_selection = 2'd2; sched_valid = 1'b1; out_ready = 1'b1;
        exp_pop_q.push_back(4'b0100); exp_pkt_q.push_back({2'd2, 64'hA5});
        exp_pop_q.push_back(4'b0100); exp_pkt_q.push_back({2'd2, 64'h5A});
        @(posedge clock); #1;
        qd[2] = 64'h5A;
        @(negedge clock);
        check("first_pop", 128'(pop), 128'(4'b0100));
        check("first_valid", 128'(out_valid), 128'(1));
        check("first_data", 128'(out_data), 128'(64'hA5));
        check("first_qid", 128'(out_queue_id), 128'(2));
        repeat (4) @(posedge clock);
        #1 sched_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1 check("after_pair_valid", 128'(out_valid), 128'(0));

        // Back-pressure: output held stable, no extra pop while stalled
        out_ready = 1'b0;
        qd[0] = 64'h1111_0000; empty = 4'b1110; sched_selection = 2'd0; sched_valid = 1'b1;
        exp_pop_q.push_back(4'b0001); exp_pkt_q.push_back({2'd0, 64'h1111_0000});
        @(posedge clock); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stall_valid", 128'(out_valid), 128'(1));
            check("stall_data", 128'(out_data), 128'(64'h1111_0000));
            check("stall_qid", 128'(out_queue_id), 128'(0));
        end
        @(posedge clock); #1;
        out_ready = 1'b1; sched_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1 check("after_stall_valid", 128'(out_valid), 128'(0));

        // Stale decision: selected queue empty, no pop until it fills
        empty = 4'b1010; sched_selection = 2'd1; sched_valid = 1'b1; qd[1] = 64'hCAFE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stale_pop", 128'(pop), 128'(0));
            check("stale_valid", 128'(out_valid), 128'(0));
        end
        @(posedge clock); #1;
        empty = 4'b1000;
        exp_pop_q.push_back(4'b0010); exp_pkt_q.push_back({2'd1, 64'hCAFE});
        @(posedge clock); #1;
        sched_valid = 1'b0;
        @(negedge clock);
        check("stale_release_pop", 128'(pop), 128'(4'b0010));
        repeat (8) @(posedge clock);
        #1;

        // Asynchronous reset while holding a packet in SEND
        out_ready = 1'b0;
        qd[3] = 64'hDEAD_BEEF; empty = 4'b0111; sched_selection = 2'd3; sched_valid = 1'b1;
        exp_pop_q.push_back(4'b1000);
        @(posedge clock); #1;
        sched_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_pop", 128'(pop), 128'(0));
        check("async_rst_data", 128'(out_data), 128'(0));
        @(posedge clock); #3;
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        sched_valid = 1'b1;
        exp_pop_q.push_back(4'b1000); exp_pkt_q.push_back({2'd3, 64'hDEAD_BEEF});
        @(posedge clock); #1;
        sched_valid = 1'b0;
        @(negedge clock);
        check("post_rst_pop", 128'(pop), 128'(4'b1000));
        check("post_rst_valid", 128'(out_valid), 128'(1));
        repeat (8) @(posedge clock);
        #1;

        // Counters: fresh reset, then five dispatches from queue 0
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        check("stats_rst_count", 128'(dispatch_count), 128'(0));
        reset = 1'b1;
        @(posedge clock); #1;
        qd[0] = 64'h77; empty = 4'b1110; sched_selection = 2'd0; sched_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_pop_q.push_back(4'b0001);
            exp_pkt_q.push_back({2'd0, 64'h77});
        end
        repeat (17) @(posedge clock);
        #1 sched_valid = 1'b0;
        repeat (8) @(posedge clock);
        #1;
`ifdef QUEUE_DISPATCHER_STATS_EN
        check("stats_count", 128'(dispatch_count), 128'(8'h03));
`else
        check("stats_count", 128'(dispatch_count), 128'(8'h00));
`endif

        check("pending_pops", 128'(exp_pop_q.size()), 128'(0));
        check("pending_packets", 128'(exp_pkt_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
